// File: rtl/din_delay_pipe.sv
// din_delay_pipe: WIDTH-bit, DEPTH-stage registered delay line with
// valid/ready handshake, back-pressure, bubble collapsing, flush and a
// run-time bypass that turns the block into a plain wire while it is empty.
module din_delay_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           din,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           dout,
    input  logic                       flush,
    input  logic                       bypass,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    // Stage state: valid bits, data words and the running word count.
    logic [DEPTH-1:0]             vld_q;
    logic [DEPTH-1:0]             vld_d;
    logic [DEPTH-1:0][WIDTH-1:0]  data_q;
    logic [DEPTH-1:0][WIDTH-1:0]  data_d;
    logic [OCC_W-1:0]             occ_q;
    logic [OCC_W-1:0]             occ_d;

    // move_s[k]: stage k hands its content downstream (or is empty) this cycle.
    logic [DEPTH-1:0]             move_s;
    logic                         occ_zero_s;
    logic                         push_s;
    logic                         pop_s;

    // Advance chain: the last stage moves when the consumer takes it or it is
    // empty; every earlier stage moves when the one below is empty or moving.
    always_comb begin
        move_s            = {DEPTH{1'b0}};
        move_s[DEPTH-1]   = ~vld_q[DEPTH-1] | out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            move_s[k] = ~vld_q[k] | move_s[k+1];
        end
    end

    // Handshake and output muxing; flush dominates, then the bypass wire path.
    always_comb begin
        occ_zero_s = (occ_q == {OCC_W{1'b0}});
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        dout       = data_q[DEPTH-1];
        if (flush) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            dout      = data_q[DEPTH-1];
        end else if (bypass) begin
            if (occ_zero_s) begin
                // Empty pipe in bypass: pure combinational wire.
                in_ready  = out_ready;
                out_valid = in_valid;
                dout      = din;
            end else begin
                // Drain what is stored before switching to the wire path.
                in_ready  = 1'b0;
                out_valid = vld_q[DEPTH-1];
                dout      = data_q[DEPTH-1];
            end
        end else begin
            in_ready  = move_s[0];
            out_valid = vld_q[DEPTH-1];
            dout      = data_q[DEPTH-1];
        end
        // Words taken by the wire path are never stored.
        push_s = in_valid & in_ready & ~bypass;
        // With the pipe empty in bypass, vld_q is all zero, so no false pop.
        pop_s  = vld_q[DEPTH-1] & out_ready & ~flush;
    end

    // Next-state for the stage chain and occupancy counter.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        occ_d  = occ_q;
        if (flush) begin
            // Discard every stored word; data contents are left as they are.
            vld_d = {DEPTH{1'b0}};
            occ_d = {OCC_W{1'b0}};
        end else begin
            if (move_s[0]) begin
                vld_d[0]  = push_s;
                data_d[0] = din;
            end else begin
                vld_d[0]  = vld_q[0];
                data_d[0] = data_q[0];
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (move_s[k]) begin
                    vld_d[k]  = vld_q[k-1];
                    data_d[k] = data_q[k-1];
                end else begin
                    vld_d[k]  = vld_q[k];
                    data_d[k] = data_q[k];
                end
            end
            occ_d = occ_q + OCC_W'(push_s) - OCC_W'(pop_s);
        end
    end

    // Stage and counter registers, cleared asynchronously on areset.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            vld_q  <= {DEPTH{1'b0}};
            data_q <= {(DEPTH*WIDTH){1'b0}};
            occ_q  <= {OCC_W{1'b0}};
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            occ_q  <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule
